// File: rtl/base3_conv_ctrl.sv
// base3_conv_ctrl: sequential binary-to-ternary converter, one trit per clock.
// div_algo is the combinational restoring divider it uses as its datapath.
module div_algo #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);
   logic [WIDTH:0] rem;
   always_comb begin
      rem = '0;
      q = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         rem = {rem[WIDTH-1:0], n[i]};
         if (rem >= {1'b0, d}) begin
            rem = rem - {1'b0, d};
            q[i] = 1'b1;
         end
      end
   end
   assign r = rem[WIDTH-1:0];
endmodule

module base3_conv_ctrl #(
   parameter int WIDTH = 16,
   parameter int NDIG  = 11,
   parameter int CW    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  n_in,
   output logic              busy,
   output logic              done,
   output logic [2*NDIG-1:0] trits,
   output logic [CW-1:0]     ndig
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] CONV = 1'b1;
   logic [0:0]       state;
   logic [WIDTH-1:0] cur;
   logic [CW-1:0]    idx;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             unused_r;
   div_algo #(.WIDTH(WIDTH)) u_div (
      .n(cur),
      .d(WIDTH'(3)),
      .q(q),
      .r(r)
   );
   // the remainder of a divide by 3 always fits in two bits
   assign unused_r = ^r[WIDTH-1:2];
   assign busy = state == CONV;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
         trits <= '0;
         ndig  <= '0;
         cur   <= '0;
         idx   <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               cur   <= n_in;
               idx   <= '0;
               trits <= '0;
               ndig  <= '0;
               state <= CONV;
            end
         end else begin
            trits[{idx, 1'b0} +: 2] <= r[1:0];
            cur  <= q;
            idx  <= idx + 1'b1;
            ndig <= idx + 1'b1;
            if (q == '0) begin
               state <= IDLE;
               done  <= 1'b1;
            end
         end
      end
   end
endmodule
